// File: rtl/stream_arb_2to1_pkg.sv
// rtl/stream_arb_2to1_pkg.sv - shared constants for the 2:1 packet stream arbiter
//
// Purpose: arbitration FSM state encodings and the default stream width,
//          shared by the arbiter top and anything that observes its state.
// Ports:   none (package).
package stream_arb_2to1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_t;

  localparam int ARB_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - single-entry registered output stage for a valid/ready stream
//
// Purpose: holds one beat. A new beat may enter only when the slot is empty
//          or is being drained in the same cycle, so the stage sustains one
//          beat per cycle with no bubble.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_accept     a beat is being handed over this cycle
//   i_data       payload of that beat (W bits)
//   o_load       slot can take a beat this cycle
//   o_valid      registered beat valid
//   i_ready      downstream accepts the registered beat
//   o_data       registered payload
module stream_out_reg #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_accept,
  input  logic [W-1:0] i_data,
  output logic         o_load,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_load  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Payload only changes on a load, so it holds steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_load) begin
      r_valid <= i_accept;
      if (i_accept) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/stream_arb_2to1.sv
// rtl/stream_arb_2to1.sv - two-input round-robin packet arbiter with registered output
//
// Purpose: forwards whole packets (delimited by last) from two valid/ready
//          inputs into one registered output stream, alternating priority
//          after every completed packet. Drives sel for the downstream 2:1 mux
//          (1 = in0 on mux input a, 0 = in1 on mux input b).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in0_valid/ready/data/last       input stream 0
//   in1_valid/ready/data/last       input stream 1
//   out_valid/ready/data/last       registered output stream
//   sel                             current grant, 1 = in0, 0 = in1
module stream_arb_2to1
  import stream_arb_2to1_pkg::*;
#(
  parameter int WIDTH = ARB_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             sel
);

  arb_state_t r_state;
  logic       r_prio;    // 0 = in0 preferred on a tie, 1 = in1 preferred

  logic           w_load;
  logic           w_idle_in0;
  logic           w_sel;
  logic           w_acc0;
  logic           w_acc1;
  logic           w_accept;
  logic           w_acc_last;
  logic [WIDTH:0] w_mux;
  logic [WIDTH:0] w_out;

  // Idle winner: a lone valid input wins; a tie or no request falls to prio.
  always_comb begin
    w_idle_in0 = !r_prio;
    if (in0_valid && !in1_valid) begin
      w_idle_in0 = 1'b1;
    end else if (in1_valid && !in0_valid) begin
      w_idle_in0 = 1'b0;
    end
  end

  always_comb begin
    w_sel = w_idle_in0;
    case (r_state)
      ST_LOCK0: w_sel = 1'b1;
      ST_LOCK1: w_sel = 1'b0;
      default:  w_sel = w_idle_in0;
    endcase
  end

  assign sel       = w_sel;
  assign in0_ready = w_load &&  w_sel;
  assign in1_ready = w_load && !w_sel;

  assign w_acc0     = in0_valid && in0_ready;
  assign w_acc1     = in1_valid && in1_ready;
  assign w_accept   = w_acc0 || w_acc1;
  assign w_mux      = w_sel ? {in0_last, in0_data} : {in1_last, in1_data};
  assign w_acc_last = w_mux[WIDTH];

  // Lock holds the grant until last; finishing a packet hands priority to
  // the other input (w_sel = 1 means in0 just finished, so prefer in1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_prio  <= 1'b0;
    end else if (w_accept) begin
      if (w_acc_last) begin
        r_state <= ST_IDLE;
        r_prio  <= w_sel;
      end else begin
        r_state <= w_sel ? ST_LOCK0 : ST_LOCK1;
      end
    end
  end

  stream_out_reg #(
    .W (WIDTH + 1)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_accept),
    .i_data   (w_mux),
    .o_load   (w_load),
    .o_valid  (out_valid),
    .i_ready  (out_ready),
    .o_data   (w_out)
  );

  assign out_data = w_out[WIDTH-1:0];
  assign out_last = w_out[WIDTH];

endmodule

// File: tb/tb_stream_arb_2to1.sv
// tb/tb_stream_arb_2to1.sv - self-checking bench for stream_arb_2to1
module tb_stream_arb_2to1;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in0_valid, in0_ready, in0_last;
  logic             in1_valid, in1_ready, in1_last;
  logic [WIDTH-1:0] in0_data, in1_data, out_data;
  logic             out_valid, out_ready, out_last, sel;

  always #5 clk = ~clk;

  stream_arb_2to1 #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in0_data  (in0_data),
    .in0_last  (in0_last),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .in1_data  (in1_data),
    .in1_last  (in1_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sel       (sel)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Source queues of {last,data} beats and the expected output backlog.
  logic [WIDTH:0] src0[$];
  logic [WIDTH:0] src1[$];
  logic [WIDTH:0] exp_q[$];
  int unsigned    p0, p1, pr;

  // Reference model: owner of the packet in flight (-1 none) and the input
  // that wins a tie.
  int   m_owner;
  int   m_pref;
  logic m_acc0, m_acc1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_pref  = 0;
    m_acc0  = 1'b0;
    m_acc1  = 1'b0;
    exp_q.delete();
    src0.delete();
    src1.delete();
  endtask

  task automatic push_pkt(input int which);
    int unsigned    len;
    logic [WIDTH:0] b;
    len = $urandom_range(4, 1);
    for (int i = 0; i < int'(len); i++) begin
      b = {(i == int'(len) - 1) ? 1'b1 : 1'b0, WIDTH'($urandom)};
      if (which == 0) src0.push_back(b);
      else            src1.push_back(b);
    end
  endtask

  task automatic cycle();
    int   win;
    logic room, e0, e1;
    @(posedge clk);
    #1;
    // A source holds its beat until the model says it was taken.
    if (!(in0_valid && !m_acc0)) begin
      if (src0.size() != 0 && $urandom_range(99) < p0) begin
        {in0_last, in0_data} = src0.pop_front();
        in0_valid = 1'b1;
      end else begin
        in0_valid = 1'b0;
        in0_data  = WIDTH'($urandom);
        in0_last  = 1'($urandom);
      end
    end
    if (!(in1_valid && !m_acc1)) begin
      if (src1.size() != 0 && $urandom_range(99) < p1) begin
        {in1_last, in1_data} = src1.pop_front();
        in1_valid = 1'b1;
      end else begin
        in1_valid = 1'b0;
        in1_data  = WIDTH'($urandom);
        in1_last  = 1'($urandom);
      end
    end
    out_ready = ($urandom_range(99) < pr);
    #3;

    if (m_owner >= 0)                 win = m_owner;
    else if (in0_valid && !in1_valid) win = 0;
    else if (in1_valid && !in0_valid) win = 1;
    else                              win = m_pref;
    room = (exp_q.size() == 0) || out_ready;
    e0   = room && (win == 0);
    e1   = room && (win == 1);

    chk("in0_ready", 32'(in0_ready), 32'(e0));
    chk("in1_ready", 32'(in1_ready), 32'(e1));
    chk("sel", 32'(sel), 32'(win == 0));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("out_beat", 32'({out_last, out_data}), 32'(exp_q[0]));

    if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
    m_acc0 = in0_valid && e0;
    m_acc1 = in1_valid && e1;
    if (m_acc0) begin
      exp_q.push_back({in0_last, in0_data});
      if (in0_last) begin m_owner = -1; m_pref = 1; end
      else          m_owner = 0;
    end
    if (m_acc1) begin
      exp_q.push_back({in1_last, in1_data});
      if (in1_last) begin m_owner = -1; m_pref = 0; end
      else          m_owner = 1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sel"},       32'(sel),       32'd1);
    chk({tag, "_in0_ready"}, 32'(in0_ready), 32'd1);
    chk({tag, "_in1_ready"}, 32'(in1_ready), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'd0);
    chk({tag, "_out_last"},  32'(out_last),  32'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in0_valid = 1'b0; in0_data = '0; in0_last = 1'b0;
    in1_valid = 1'b0; in1_data = '0; in1_last = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check_reset_values("por");
    #11;
    rst_n = 1'b1;

    // Single in0 beat.
    src0.push_back({1'b1, 8'hA5});
    p0 = 100; p1 = 0; pr = 100;
    cycle();
    cycle();
    chk("a5_data", 32'(out_data), 32'h0A5);
    chk("a5_last", 32'(out_last), 32'd1);

    // Competing single-beat packets alternate every cycle.
    for (int i = 0; i < 6; i++) begin
      src0.push_back({1'b1, 8'h11});
      src1.push_back({1'b1, 8'h22});
    end
    p0 = 100; p1 = 100;
    repeat (14) cycle();

    // 3-beat in0 packet while in1 waits, with a 4-cycle stall mid-packet.
    src1.push_back({1'b1, 8'h44});
    src1.push_back({1'b1, 8'h55});
    src0.push_back({1'b0, 8'h01});
    src0.push_back({1'b0, 8'h02});
    src0.push_back({1'b1, 8'h03});
    repeat (2) cycle();
    pr = 0;
    repeat (4) cycle();
    pr = 100;
    repeat (6) cycle();

    // Reset in the middle of an in1 packet.
    src1.push_back({1'b0, 8'h61});
    src1.push_back({1'b0, 8'h62});
    src1.push_back({1'b0, 8'h63});
    src1.push_back({1'b1, 8'h64});
    p0 = 0; p1 = 100;
    repeat (2) cycle();
    pulse_reset();
    src0.push_back({1'b1, 8'h71});
    src1.push_back({1'b1, 8'h72});
    p0 = 100; p1 = 100;
    cycle();
    chk("post_rst_sel", 32'(sel), 32'd1);
    cycle();
    chk("post_rst_first", 32'(out_data), 32'h071);
    repeat (3) cycle();

    // Random traffic and backpressure.
    for (int blk = 0; blk < 20; blk++) begin
      p0 = $urandom_range(100, 20);
      p1 = $urandom_range(100, 20);
      pr = $urandom_range(100, 30);
      for (int c = 0; c < 200; c++) begin
        if (src0.size() < 2) push_pkt(0);
        if (src1.size() < 2) push_pkt(1);
        cycle();
      end
      if (blk == 10) pulse_reset();
    end

    p0 = 0; p1 = 0; pr = 100;
    repeat (12) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
